// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word over req/ack and issues it to decode.
// Latency: one cycle from ack to inst_valid; with zero-wait memory one instruction per 2 cycles.
// Backpressure: waits in FETCH until imem_ack and in ISSUE until inst_ready; state and outputs hold while waiting.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction memory handshake (addr always equals pc)
//   inst_valid/inst_ready      valid-ready handshake with decode for the held word
//   instr, Opcode, Funct, pc   held instruction, its decoded fields and its address
//   Branch_*, jump             branch strobes and jump type returned by decode
//   rs_data, rt_data           register operands used for branch compare and jr
//   retired                    count of consumed instructions (wraps)

module pc_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,

    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,

    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         instr,
    output logic [5:0]          Opcode,
    output logic [5:0]          Funct,
    output logic [PC_WIDTH-1:0] pc,

    input  logic                Branch_gtz,
    input  logic                Branch_ne,
    input  logic                Branch_eq,
    input  logic                Branch_gez,
    input  logic                Branch_lez,
    input  logic                Branch_ltz,
    input  logic [1:0]          jump,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,

    output logic [31:0]         retired
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    // Bits of pc_plus4 that survive a j: everything above the 28-bit region.
    localparam logic [PC_WIDTH-1:0] REGION_MASK = ~PC_WIDTH'(32'h0FFF_FFFF);

    logic [0:0]          state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         instr_q;
    logic [31:0]         retired_q;
    logic                req_q;

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] jr_tgt;
    logic [PC_WIDTH-1:0] j_tgt;
    logic [PC_WIDTH-1:0] br_tgt;
    logic [31:0]         br_off;
    logic [PC_WIDTH-1:0] next_pc;

    logic rs_neg;
    logic rs_zero;
    logic c_gtz;
    logic c_gez;
    logic c_lez;
    logic c_ltz;
    logic c_eq;
    logic c_ne;
    logic regimm_taken;
    logic br_taken;
    logic consume;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst_valid = (state_q == ST_ISSUE);
    assign instr      = instr_q;
    assign Opcode     = instr_q[31:26];
    assign Funct      = instr_q[5:0];
    assign retired    = retired_q;

    assign consume = inst_valid & inst_ready;

    // ------------------------------------------------------------------
    // Branch condition evaluation (signed compare against zero on rs)
    // ------------------------------------------------------------------
    always_comb begin
        rs_neg  = rs_data[31];
        rs_zero = (rs_data == 32'd0);
        c_gtz   = ~rs_neg & ~rs_zero;
        c_gez   = ~rs_neg;
        c_lez   = rs_neg | rs_zero;
        c_ltz   = rs_neg;
        c_eq    = (rs_data == rt_data);
        c_ne    = ~c_eq;

        // Opcode 1 carries both bgez and bltz; decode raises both strobes
        // and instr[16] picks which condition actually applies.
        if (Branch_gez && Branch_ltz) begin
            regimm_taken = instr_q[16] ? c_gez : c_ltz;
        end else begin
            regimm_taken = (Branch_gez & c_gez) | (Branch_ltz & c_ltz);
        end

        br_taken = regimm_taken
                 | (Branch_gtz & c_gtz)
                 | (Branch_lez & c_lez)
                 | (Branch_eq  & c_eq)
                 | (Branch_ne  & c_ne);
    end

    // ------------------------------------------------------------------
    // Next-PC selection: jr > j > taken branch > sequential
    // ------------------------------------------------------------------
    always_comb begin
        pc_plus4 = pc_q + PC_WIDTH'(4);

        // jr targets are word aligned regardless of the register's low bits.
        jr_tgt = PC_WIDTH'(rs_data & 32'hFFFF_FFFC);

        j_tgt = (pc_plus4 & REGION_MASK) | PC_WIDTH'({instr_q[25:0], 2'b00});

        // Word offset, sign-extended before scaling so backward branches wrap.
        br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        br_tgt = pc_plus4 + PC_WIDTH'($signed(br_off));

        next_pc = pc_plus4;
        if (jump == JUMP_JR) begin
            next_pc = jr_tgt;
        end else if (jump == JUMP_J) begin
            next_pc = j_tgt;
        end else if (br_taken) begin
            next_pc = br_tgt;
        end else if (jump == JUMP_NONE) begin
            next_pc = pc_plus4;
        end else begin
            // Reserved jump encoding falls through to sequential fetch.
            next_pc = pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Fetch/issue state machine
    // ------------------------------------------------------------------
    // imem_req is registered so it stays low throughout reset and rises on
    // the first edge after release. In FETCH an ack is taken even in that
    // first cycle, so a late ack after reset counts as the RESET_PC fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            req_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b0;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // Memory acks here are stale or spurious and are dropped.
                    if (consume) begin
                        pc_q      <= next_pc;
                        retired_q <= retired_q + 32'd1;
                        state_q   <= ST_FETCH;
                        req_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by randomized traffic,
// every cycle compared against an arithmetic model of fetch/issue and next-PC rules.
// Inputs are driven and outputs sampled on the falling edge.

module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instr;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [31:0] pc;
    logic        Branch_gtz, Branch_ne, Branch_eq, Branch_gez, Branch_lez, Branch_ltz;
    logic [1:0]  jump;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] retired;

    always #5 clk = ~clk;

    pc_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instr(instr),
        .Opcode(Opcode), .Funct(Funct), .pc(pc),
        .Branch_gtz(Branch_gtz), .Branch_ne(Branch_ne), .Branch_eq(Branch_eq),
        .Branch_gez(Branch_gez), .Branch_lez(Branch_lez), .Branch_ltz(Branch_ltz),
        .jump(jump), .rs_data(rs_data), .rt_data(rt_data), .retired(retired)
    );

    // br vector order: {gtz, ne, eq, gez, lez, ltz}
    localparam logic [5:0] BR_NONE = 6'b000000;
    localparam logic [5:0] BR_EQ   = 6'b001000;
    localparam logic [5:0] BR_GL   = 6'b000101;

    int n_total = 0;
    int n_bad   = 0;

    // Model of the visible state.
    logic [31:0] m_pc, m_instr, m_ret;
    bit          m_valid, m_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [31:0] ins,
                                                input logic [1:0] jmp, input logic [5:0] br,
                                                input logic [31:0] rs, input logic [31:0] rt);
        longint m;
        longint p4;
        longint off;
        int     srs;
        bit     t;
        m   = 64'h1_0000_0000;
        p4  = (longint'(cur_pc) + 4) % m;
        srs = $signed(rs);
        if (jmp == 2'b10) return 32'((longint'(rs) / 4) * 4);
        if (jmp == 2'b01) return 32'((p4 / (64'd1 << 28)) * (64'd1 << 28) + (longint'(ins) % (64'd1 << 26)) * 4);
        if (br[2] && br[0]) t = ins[16] ? (srs >= 0) : (srs < 0);
        else                t = (br[2] && srs >= 0) || (br[0] && srs < 0);
        t = t || (br[5] && srs > 0) || (br[1] && srs <= 0) || (br[3] && rs == rt) || (br[4] && rs != rt);
        if (t) begin
            off = longint'($signed(ins[15:0])) * 4;
            return 32'((p4 + off + m) % m);
        end
        return 32'(p4);
    endfunction

    // One cycle: compare outputs with the model, drive inputs, predict the edge.
    task automatic step(input bit ack, input logic [31:0] rdata, input bit rdy,
                        input logic [1:0] jmp, input logic [5:0] br,
                        input logic [31:0] rs, input logic [31:0] rt);
        check("req", 32'(imem_req), 32'(m_req));
        check("valid", 32'(inst_valid), 32'(m_valid));
        check("pc", pc, m_pc);
        check("retired", retired, m_ret);
        if (m_req) check("addr", imem_addr, m_pc);
        if (m_valid) begin
            check("instr", instr, m_instr);
            check("opcode", 32'(Opcode), 32'(m_instr[31:26]));
            check("funct", 32'(Funct), 32'(m_instr[5:0]));
        end
        imem_ack   = ack;
        imem_rdata = rdata;
        inst_ready = rdy;
        jump       = jmp;
        {Branch_gtz, Branch_ne, Branch_eq, Branch_gez, Branch_lez, Branch_ltz} = br;
        rs_data    = rs;
        rt_data    = rt;
        if (!m_valid && ack) begin
            m_instr = rdata;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_pc    = ref_next_pc(m_pc, m_instr, jmp, br, rs, rt);
            m_ret   = m_ret + 1;
            m_valid = 1'b0;
        end
        m_req = !m_valid;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 2'b00, BR_NONE, 32'h0, 32'h0);
    endtask

    // Fetch a word with zero wait, then consume it with the given decode inputs.
    task automatic issue_one(input logic [31:0] ins, input logic [1:0] jmp, input logic [5:0] br,
                             input logic [31:0] rs, input logic [31:0] rt);
        step(1'b1, ins, 1'b0, 2'b00, BR_NONE, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, jmp, br, rs, rt);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0; m_valid = 1'b0; m_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rs, rt, rd;
        logic [5:0]  br;
        logic [1:0]  jmp;
        int          r;

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        jump = 2'b00; rs_data = 32'h0; rt_data = 32'h0;
        {Branch_gtz, Branch_ne, Branch_eq, Branch_gez, Branch_lez, Branch_ltz} = BR_NONE;
        model_reset();
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_retired", retired, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("first_req", 32'(imem_req), 32'h1);

        // Zero-wait stream of add instructions.
        for (int i = 0; i < 3; i++) begin
            check("zw_addr", imem_addr, 32'(i * 4));
            step(1'b1, 32'h0000_0020, 1'b0, 2'b00, BR_NONE, 32'h0, 32'h0);
            check("zw_opcode", 32'(Opcode), 32'h0);
            check("zw_funct", 32'(Funct), 32'h20);
            step(1'b0, 32'h0, 1'b1, 2'b00, BR_NONE, 32'h0, 32'h0);
            check("zw_retired", retired, 32'(i + 1));
        end

        // Slow memory, then a stalled consumer with junk acks in ISSUE.
        repeat (3) begin
            step(1'b0, 32'h0, 1'b0, 2'b00, BR_NONE, 32'h0, 32'h0);
            check("wait_addr", imem_addr, 32'hC);
            check("wait_req", 32'(imem_req), 32'h1);
        end
        step(1'b1, 32'h0000_0020, 1'b0, 2'b00, BR_NONE, 32'h0, 32'h0);
        check("ack_valid", 32'(inst_valid), 32'h1);
        repeat (4) begin
            step(1'b1, 32'hFFFF_FFFF, 1'b0, 2'b00, BR_NONE, 32'h0, 32'h0);
            check("stall_instr", instr, 32'h0000_0020);
            check("stall_retired", retired, 32'd3);
        end
        step(1'b0, 32'h0, 1'b1, 2'b00, BR_NONE, 32'h0, 32'h0);
        check("stall_pc", pc, 32'h10);

        // beq backward (taken) and not taken.
        issue_one(32'h0800_0000, 2'b10, BR_NONE, 32'h100, 32'h0);
        check("jr_100", pc, 32'h100);
        issue_one({6'h04, 5'd1, 5'd2, 16'hFFFE}, 2'b00, BR_EQ, 32'd5, 32'd5);
        check("beq_taken", pc, 32'hFC);
        issue_one(32'h0, 2'b10, BR_NONE, 32'h100, 32'h0);
        issue_one({6'h04, 5'd1, 5'd2, 16'hFFFE}, 2'b00, BR_EQ, 32'd5, 32'd6);
        check("beq_not", pc, 32'h104);

        // Shared opcode 1 with both strobes, rs negative.
        issue_one(32'h0, 2'b10, BR_NONE, 32'h40, 32'h0);
        issue_one({6'h01, 5'd1, 5'b00000, 16'h0004}, 2'b00, BR_GL, 32'hFFFF_FFFF, 32'h0);
        check("bltz_taken", pc, 32'h54);
        issue_one(32'h0, 2'b10, BR_NONE, 32'h40, 32'h0);
        issue_one({6'h01, 5'd1, 5'b00001, 16'h0004}, 2'b00, BR_GL, 32'hFFFF_FFFF, 32'h0);
        check("bgez_not", pc, 32'h44);

        // j keeps the upper region, jr aligns, reserved jump is sequential.
        issue_one(32'h0, 2'b10, BR_NONE, 32'h1000_0010, 32'h0);
        issue_one({6'h02, 26'h000_0100}, 2'b01, BR_NONE, 32'h0, 32'h0);
        check("j_target", pc, 32'h1000_0400);
        issue_one(32'h0, 2'b10, BR_NONE, 32'h0000_2003, 32'h0);
        check("jr_align", pc, 32'h2000);
        issue_one(32'h0, 2'b11, BR_NONE, 32'h0, 32'h0);
        check("jump_rsvd", pc, 32'h2004);

        // Asynchronous reset in the middle of ISSUE.
        issue_one(32'h0, 2'b10, BR_NONE, 32'h200, 32'h0);
        step(1'b1, 32'h0000_0020, 1'b0, 2'b00, BR_NONE, 32'h0, 32'h0);
        check("pre_rst_pc", pc, 32'h200);
        #2 rst_n = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("arst_valid", 32'(inst_valid), 32'h0);
        check("arst_pc", pc, 32'h0);
        check("arst_retired", retired, 32'h0);
        check("arst_req", 32'(imem_req), 32'h0);
        model_reset();
        @(negedge clk);
        check("arst_hold_pc", pc, 32'h0);
        rst_n = 1'b1;
        idle();
        check("restart_req", 32'(imem_req), 32'h1);
        check("restart_addr", imem_addr, 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       br = 6'(1 << r);
            else if (r == 6) br = BR_GL;
            else             br = BR_NONE;
            r = $urandom_range(0, 9);
            jmp = (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b00;
            r = $urandom_range(0, 3);
            rs = (r == 0) ? 32'h0 : (r == 1) ? 32'h1 : (r == 2) ? 32'hFFFF_FFFF : $urandom;
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            rd = $urandom;
            step(m_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0), rd,
                 ($urandom_range(0, 2) != 0), jmp, br, rs, rt);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
